// File: rtl/subleq_ctrl.sv
// Control FSM for the 64-bit SUBLEQ core: sequences fetch/read/exec/write/PC update over a req/ready memory.
// Optional halt-on-negative-branch behaviour is enabled by defining SUBLEQ_HALT_EN.
module subleq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mem_ready,
  input  logic        leq,
  input  logic        c_neg,
  output logic [2:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  addr_sel,
  output logic        ld_a,
  output logic        ld_b,
  output logic        ld_c,
  output logic        ld_ma,
  output logic        ld_mb,
  output logic        ld_res,
  output logic        pc_ld,
  output logic        pc_we,
  output logic        halted,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    FETCH_A   = 3'b000,
    FETCH_B   = 3'b001,
    FETCH_C   = 3'b010,
    READ_A    = 3'b011,
    READ_B    = 3'b100,
    EXEC      = 3'b101,
    WRITE_B   = 3'b110,
    UPDATE_PC = 3'b111
  } state_e;

  state_e      state_q, state_d;
  logic        leq_q, leq_d;
  logic        halted_q, halted_d;
  logic        req_pend_q, req_pend_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        halt_hit_s;

`ifdef SUBLEQ_HALT_EN
  assign halt_hit_s = leq_q & c_neg;
`else
  logic unused_c_neg_s;
  assign unused_c_neg_s = c_neg;
  assign halt_hit_s     = 1'b0;
`endif

  // State and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_A;
      leq_q       <= 1'b0;
      halted_q    <= 1'b0;
      req_pend_q  <= 1'b0;
      instr_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      leq_q       <= leq_d;
      halted_q    <= halted_d;
      req_pend_q  <= req_pend_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Next-state and strobe decode from registered state, run, mem_ready and leq_q
  always_comb begin
    state_d     = state_q;
    leq_d       = leq_q;
    halted_d    = halted_q;
    req_pend_d  = 1'b0;
    instr_cnt_d = instr_cnt_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 3'd0;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    ld_c        = 1'b0;
    ld_ma       = 1'b0;
    ld_mb       = 1'b0;
    ld_res      = 1'b0;
    pc_ld       = 1'b0;
    pc_we       = 1'b0;
    if (rst || halted_q) begin
      state_d = state_q;
    end else begin
      case (state_q)
        FETCH_A: begin
          // A started fetch keeps requesting even if run drops before ready
          if (run || req_pend_q) begin
            mem_req  = 1'b1;
            addr_sel = 3'd0;
            if (mem_ready) begin
              ld_a    = 1'b1;
              state_d = FETCH_B;
            end else begin
              req_pend_d = 1'b1;
            end
          end else begin
            state_d = FETCH_A;
          end
        end
        FETCH_B: begin
          mem_req  = 1'b1;
          addr_sel = 3'd1;
          if (mem_ready) begin
            ld_b    = 1'b1;
            state_d = FETCH_C;
          end else begin
            state_d = FETCH_B;
          end
        end
        FETCH_C: begin
          mem_req  = 1'b1;
          addr_sel = 3'd2;
          if (mem_ready) begin
            ld_c    = 1'b1;
            state_d = READ_A;
          end else begin
            state_d = FETCH_C;
          end
        end
        READ_A: begin
          mem_req  = 1'b1;
          addr_sel = 3'd3;
          if (mem_ready) begin
            ld_ma   = 1'b1;
            state_d = READ_B;
          end else begin
            state_d = READ_A;
          end
        end
        READ_B: begin
          mem_req  = 1'b1;
          addr_sel = 3'd4;
          if (mem_ready) begin
            ld_mb   = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = READ_B;
          end
        end
        EXEC: begin
          ld_res  = 1'b1;
          state_d = WRITE_B;
        end
        WRITE_B: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 3'd4;
          if (mem_ready) begin
            leq_d   = leq;
            state_d = UPDATE_PC;
          end else begin
            state_d = WRITE_B;
          end
        end
        UPDATE_PC: begin
          instr_cnt_d = instr_cnt_q + 32'd1;
          // Halting branch retires the instruction but never commits the PC
          if (halt_hit_s) begin
            halted_d = 1'b1;
            state_d  = UPDATE_PC;
          end else begin
            pc_we   = 1'b1;
            pc_ld   = leq_q;
            state_d = FETCH_A;
          end
        end
        default: begin
          state_d = FETCH_A;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign halted    = halted_q;
  assign instr_cnt = instr_cnt_q;

endmodule
